// File: rtl/mc_control.sv
// Multicycle MIPS control sequencer: steps each instruction through fetch/decode/execute/memory/writeback
// and drives the shared-datapath enables, waiting on a variable-latency memory port.
module mc_control #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ir_write,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             ext_op,
   output logic             jal_en,
   output logic             lui_en,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MADDR  = 4'd3,
      S_MRD    = 4'd4,
      S_MWB    = 4'd5,
      S_MWR    = 4'd6,
      S_EXR    = 4'd7,
      S_RWB    = 4'd8,
      S_BR     = 4'd9,
      S_JMP    = 4'd10,
      S_EXI    = 4'd11,
      S_IWB    = 4'd12,
      S_JR     = 4'd13,
      S_TRAP   = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // Last wait cycle allowed before an access without mem_ready traps.
   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

   state_t     cur_state, nxt_state;
   logic [7:0] wait_cnt, wait_nxt;
   logic       mem_state;
   logic       trap_set;
   logic [1:0] cause_set;

   assign state = cur_state;

   // NOTE: every signal driven here gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      pc_source  = 2'b00;
      ext_op     = 1'b1;
      jal_en     = 1'b0;
      lui_en     = 1'b0;
      instr_done = 1'b0;
      nxt_state  = cur_state;
      wait_nxt   = 8'd0;
      mem_state  = 1'b0;
      trap_set   = 1'b0;
      cause_set  = 2'b00;

      case (cur_state)
         S_RST: begin
            ext_op    = 1'b0;
            nxt_state = S_FETCH;
         end
         S_FETCH: begin
            mem_state = 1'b1;
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               nxt_state = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE:                 nxt_state = (funct == FN_JR) ? S_JR : S_EXR;
               OP_LW, OP_SW:             nxt_state = S_MADDR;
               OP_BEQ, OP_BNE:           nxt_state = S_BR;
               OP_J, OP_JAL:             nxt_state = S_JMP;
               OP_ADDI, OP_SLTI, OP_SLTIU,
               OP_ANDI, OP_ORI, OP_XORI,
               OP_LUI:                   nxt_state = S_EXI;
               default: begin
                  nxt_state = S_TRAP;
                  trap_set  = 1'b1;
                  cause_set = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = (opcode == OP_SW) ? S_MWR : S_MRD;
         end
         S_MRD: begin
            mem_state = 1'b1;
            mem_read  = 1'b1;
            iord      = 1'b1;
            if (mem_ready) nxt_state = S_MWB;
         end
         S_MWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_MWR: begin
            mem_state = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               nxt_state  = S_FETCH;
            end
         end
         S_EXR: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
            nxt_state = S_RWB;
         end
         S_RWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_EXI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (opcode)
               OP_SLTI:  alu_op = 3'b100;
               OP_SLTIU: alu_op = 3'b101;
               OP_ANDI, OP_ORI, OP_XORI: begin
                  alu_op = 3'b011;
                  ext_op = 1'b0;
               end
               OP_LUI:   lui_en = 1'b1;
               default:  alu_op = 3'b000;
            endcase
            nxt_state = S_IWB;
         end
         S_IWB: begin
            reg_write  = 1'b1;
            lui_en     = (opcode == OP_LUI);
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_BR: begin
            alu_src_a  = 1'b1;
            alu_op     = 3'b001;
            pc_source  = 2'b01;
            pc_write   = (opcode == OP_BNE) ? !zero : zero;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_JMP: begin
            pc_source  = 2'b10;
            pc_write   = 1'b1;
            reg_write  = (opcode == OP_JAL);
            jal_en     = (opcode == OP_JAL);
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_JR: begin
            pc_source  = 2'b11;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_TRAP: begin
            ext_op = 1'b0;
         end
         default: begin
            ext_op    = 1'b0;
            nxt_state = S_RST;
         end
      endcase

      // A ready on the final allowed wait cycle still completes the access.
      if (mem_state && !mem_ready) begin
         if (wait_cnt >= WAIT_LIMIT) begin
            nxt_state = S_TRAP;
            trap_set  = 1'b1;
            cause_set = CAUSE_TIMEOUT;
         end else begin
            wait_nxt = wait_cnt + 8'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments and clears asynchronously on rst_n, even mid-access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state  <= S_RST;
         wait_cnt   <= 8'd0;
         retired    <= '0;
         trap       <= 1'b0;
         trap_cause <= 2'b00;
      end else begin
         cur_state <= nxt_state;
         wait_cnt  <= wait_nxt;
         if (instr_done) retired <= retired + CNT_W'(1);
         if (trap_set && !trap) begin
            trap       <= 1'b1;
            trap_cause <= cause_set;
         end
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus pushes per-cycle expected state/controls, a negedge monitor
// pops and compares them against the DUT.
module tb_mc_control;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       ext_op;
      logic       jal_en;
      logic       lui_en;
      logic       instr_done;
   } ctl_t;

   typedef struct packed {
      logic [3:0]  st;
      ctl_t        c;
      logic [31:0] ret;
      logic [1:0]  cause;
   } item_t;

   localparam ctl_t C_OFF   = '0;
   localparam ctl_t C_FW    = '{mem_read: 1'b1, alu_src_b: 2'b01, ext_op: 1'b1, default: 0};
   localparam ctl_t C_FR    = '{pc_write: 1'b1, ir_write: 1'b1, mem_read: 1'b1, alu_src_b: 2'b01, ext_op: 1'b1, default: 0};
   localparam ctl_t C_DEC   = '{alu_src_b: 2'b11, ext_op: 1'b1, default: 0};
   localparam ctl_t C_EXR   = '{alu_src_a: 1'b1, alu_op: 3'b010, ext_op: 1'b1, default: 0};
   localparam ctl_t C_RWB   = '{reg_write: 1'b1, reg_dst: 1'b1, instr_done: 1'b1, ext_op: 1'b1, default: 0};
   localparam ctl_t C_MADDR = '{alu_src_a: 1'b1, alu_src_b: 2'b10, ext_op: 1'b1, default: 0};
   localparam ctl_t C_MRD   = '{mem_read: 1'b1, iord: 1'b1, ext_op: 1'b1, default: 0};
   localparam ctl_t C_MWB   = '{reg_write: 1'b1, mem_to_reg: 1'b1, instr_done: 1'b1, ext_op: 1'b1, default: 0};
   localparam ctl_t C_MWR   = '{mem_write: 1'b1, iord: 1'b1, ext_op: 1'b1, default: 0};
   localparam ctl_t C_MWRD  = '{mem_write: 1'b1, iord: 1'b1, instr_done: 1'b1, ext_op: 1'b1, default: 0};
   localparam ctl_t C_BRT   = '{pc_write: 1'b1, alu_src_a: 1'b1, alu_op: 3'b001, pc_source: 2'b01,
                                instr_done: 1'b1, ext_op: 1'b1, default: 0};
   localparam ctl_t C_BRN   = '{alu_src_a: 1'b1, alu_op: 3'b001, pc_source: 2'b01,
                                instr_done: 1'b1, ext_op: 1'b1, default: 0};
   localparam ctl_t C_JAL   = '{pc_write: 1'b1, reg_write: 1'b1, pc_source: 2'b10, jal_en: 1'b1,
                                instr_done: 1'b1, ext_op: 1'b1, default: 0};
   localparam ctl_t C_ANDI  = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b011, ext_op: 1'b0, default: 0};
   localparam ctl_t C_IWB   = '{reg_write: 1'b1, instr_done: 1'b1, ext_op: 1'b1, default: 0};
   localparam ctl_t C_JR    = '{pc_write: 1'b1, pc_source: 2'b11, instr_done: 1'b1, ext_op: 1'b1, default: 0};

   logic        clk = 1'b0;
   logic        rst_n, zero, mem_ready;
   logic [5:0]  opcode, funct;
   logic        pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, pc_source, trap_cause;
   logic [2:0]  alu_op;
   logic        ext_op, jal_en, lui_en, instr_done, trap;
   logic [31:0] retired;
   logic [3:0]  state;
   ctl_t        act_ctl;

   int          total = 0;
   int          bad   = 0;
   item_t       sb[$];
   item_t       mon_it;
   logic [31:0] exp_ret;
   logic [5:0]  p_op, p_fn;

   always #5 clk = ~clk;

   mc_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .ext_op(ext_op), .jal_en(jal_en),
      .lui_en(lui_en), .instr_done(instr_done), .retired(retired), .trap(trap), .trap_cause(trap_cause),
      .state(state)
   );

   assign act_ctl = {pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                     alu_src_a, alu_src_b, alu_op, pc_source, ext_op, jal_en, lui_en, instr_done};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle away from the active edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_it = sb.pop_front();
         check("state", {28'd0, state}, {28'd0, mon_it.st});
         check("controls", {12'd0, act_ctl}, {12'd0, mon_it.c});
         check("retired", retired, mon_it.ret);
         check("trap", {29'd0, trap, trap_cause}, {29'd0, (mon_it.cause != 2'b00), mon_it.cause});
      end
   end

   task automatic load(input logic [5:0] op, input logic [5:0] fn);
      p_op = op;
      p_fn = fn;
   endtask

   // Applies one cycle of inputs and records what the DUT must show during that cycle.
   task automatic step(input logic rst_v, input logic rdy, input logic z,
                       input logic [3:0] st, input ctl_t c, input logic [1:0] cause);
      item_t it;
      @(posedge clk);
      #1;
      rst_n     = rst_v;
      mem_ready = rdy;
      zero      = z;
      opcode    = p_op;
      funct     = p_fn;
      if (!rst_v) exp_ret = 32'd0;
      it.st    = st;
      it.c     = c;
      it.ret   = exp_ret;
      it.cause = cause;
      sb.push_back(it);
      if (c.instr_done) exp_ret = exp_ret + 32'd1;
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
      p_op = '0; p_fn = '0; exp_ret = 32'd0;

      step(0, 0, 0, 4'd0, C_OFF, 2'd0);
      step(0, 0, 0, 4'd0, C_OFF, 2'd0);
      step(1, 0, 0, 4'd0, C_OFF, 2'd0);

      // add, memory ready on the first fetch cycle
      load(6'h00, 6'h20);
      step(1, 1, 0, 4'd1, C_FR, 2'd0);
      step(1, 0, 0, 4'd2, C_DEC, 2'd0);
      step(1, 0, 0, 4'd7, C_EXR, 2'd0);
      step(1, 0, 0, 4'd8, C_RWB, 2'd0);

      // lw, ready arrives on the fourth cycle of both FETCH and MRD (the last allowed wait cycle)
      load(6'h23, 6'h00);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd1, C_FW, 2'd0);
      step(1, 1, 0, 4'd1, C_FR, 2'd0);
      step(1, 0, 0, 4'd2, C_DEC, 2'd0);
      step(1, 0, 0, 4'd3, C_MADDR, 2'd0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd4, C_MRD, 2'd0);
      step(1, 1, 0, 4'd4, C_MRD, 2'd0);
      step(1, 0, 0, 4'd5, C_MWB, 2'd0);

      // sw with one wait cycle
      load(6'h2b, 6'h00);
      step(1, 1, 0, 4'd1, C_FR, 2'd0);
      step(1, 0, 0, 4'd2, C_DEC, 2'd0);
      step(1, 0, 0, 4'd3, C_MADDR, 2'd0);
      step(1, 0, 0, 4'd6, C_MWR, 2'd0);
      step(1, 1, 0, 4'd6, C_MWRD, 2'd0);

      // beq and bne, both with zero=1
      load(6'h04, 6'h00);
      step(1, 1, 1, 4'd1, C_FR, 2'd0);
      step(1, 0, 1, 4'd2, C_DEC, 2'd0);
      step(1, 0, 1, 4'd9, C_BRT, 2'd0);
      load(6'h05, 6'h00);
      step(1, 1, 1, 4'd1, C_FR, 2'd0);
      step(1, 0, 1, 4'd2, C_DEC, 2'd0);
      step(1, 0, 1, 4'd9, C_BRN, 2'd0);

      // jal, andi, jr
      load(6'h03, 6'h00);
      step(1, 1, 0, 4'd1, C_FR, 2'd0);
      step(1, 0, 0, 4'd2, C_DEC, 2'd0);
      step(1, 0, 0, 4'd10, C_JAL, 2'd0);
      load(6'h0c, 6'h00);
      step(1, 1, 0, 4'd1, C_FR, 2'd0);
      step(1, 0, 0, 4'd2, C_DEC, 2'd0);
      step(1, 0, 0, 4'd11, C_ANDI, 2'd0);
      step(1, 0, 0, 4'd12, C_IWB, 2'd0);
      load(6'h00, 6'h08);
      step(1, 1, 0, 4'd1, C_FR, 2'd0);
      step(1, 0, 0, 4'd2, C_DEC, 2'd0);
      step(1, 0, 0, 4'd13, C_JR, 2'd0);

      // reset asserted mid-FETCH while memory is stalled
      load(6'h00, 6'h20);
      step(1, 0, 0, 4'd1, C_FW, 2'd0);
      step(0, 0, 0, 4'd0, C_OFF, 2'd0);
      step(0, 0, 0, 4'd0, C_OFF, 2'd0);
      step(1, 0, 0, 4'd0, C_OFF, 2'd0);

      // illegal opcode traps from DECODE and stays trapped
      load(6'h3f, 6'h00);
      step(1, 1, 0, 4'd1, C_FR, 2'd0);
      step(1, 0, 0, 4'd2, C_DEC, 2'd0);
      step(1, 0, 0, 4'd14, C_OFF, 2'd1);
      step(1, 1, 1, 4'd14, C_OFF, 2'd1);
      step(1, 1, 0, 4'd14, C_OFF, 2'd1);
      step(0, 0, 0, 4'd0, C_OFF, 2'd0);
      step(1, 0, 0, 4'd0, C_OFF, 2'd0);

      // memory timeout in FETCH after four wait cycles
      load(6'h00, 6'h20);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 4'd1, C_FW, 2'd0);
      step(1, 0, 0, 4'd14, C_OFF, 2'd2);
      step(1, 1, 0, 4'd14, C_OFF, 2'd2);
      step(1, 0, 0, 4'd14, C_OFF, 2'd2);
      step(0, 0, 0, 4'd0, C_OFF, 2'd0);
      step(1, 0, 0, 4'd0, C_OFF, 2'd0);
      step(1, 1, 0, 4'd1, C_FR, 2'd0);

      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
